go_request_conditioner: RTL and testbench

GO_REQUEST_CONDITIONER -- requirements
Module: go_request_conditioner

---
 rtl/go_request_conditioner.sv | 156 +++++++++++++++
 tb/tb_go_request_conditioner.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/go_request_conditioner.sv
// go_request_conditioner: synchronizes and debounces a push button, then turns each clean press into a go/done handshake.
// Latency: btnInput edge -> btnClean after 2+DEBOUNCE_CYCLES clk cycles; btnClean rise -> goOut high on the next cycle.
// Backpressure: goOut holds until doneIn answers; presses arriving while busy are dropped, never queued or counted.
// Optional feature macro: GO_PULSE_OUT_EN builds the goPulse strobe register; without it goPulse is tied to 0.
module go_request_conditioner #(
   parameter int unsigned DEBOUNCE_CYCLES = 120000
) (
   input  logic       clk,
   input  logic       rstN,
   input  logic       btnInput,
   input  logic       doneIn,
   output logic       goOut,
   output logic       busy,
   output logic       btnClean,
   output logic [7:0] pressCount,
   output logic       goPulse
);

   // The counter is sized for the largest legal DEBOUNCE_CYCLES (2^20-1).
   localparam logic [19:0] DB_LAST = 20'(DEBOUNCE_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE    = 2'b00,
      S_REQ     = 2'b01,
      S_RELEASE = 2'b10
   } state_t;

   logic        btnMeta;
   logic        btnSync;
   logic        doneMeta;
   logic        doneSync;
   logic [1:0]  syncFill;
   logic [19:0] dbCnt;
   logic        btnCleanDly;
   logic        releaseSeen;
   logic        cleanRise;
   logic        idleToReq;
   state_t      state;
   state_t      stateNext;

   // Two-flop synchronizers for both asynchronous inputs; syncFill marks when btnSync holds real samples.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         btnMeta  <= 1'b0;
         btnSync  <= 1'b0;
         doneMeta <= 1'b0;
         doneSync <= 1'b0;
         syncFill <= 2'b00;
      end else begin
         btnMeta  <= btnInput;
         btnSync  <= btnMeta;
         doneMeta <= doneIn;
         doneSync <= doneMeta;
         syncFill <= {syncFill[0], 1'b1};
      end
   end

   // Debounce: count consecutive cycles the synchronized button disagrees with btnClean.
   // The count clears on the toggle itself, so it never passes DB_LAST and cannot wrap.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         dbCnt    <= '0;
         btnClean <= 1'b0;
      end else if (btnSync != btnClean) begin
         if (dbCnt == DB_LAST) begin
            btnClean <= ~btnClean;
            dbCnt    <= '0;
         end else begin
            dbCnt <= dbCnt + 20'd1;
         end
      end else begin
         dbCnt <= '0;
      end
   end

   // Registered edge detect on btnClean. releaseSeen arms it only after the button has been seen
   // released since reset, so a button held through reset settles to btnClean=1 without a request.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         btnCleanDly <= 1'b0;
         releaseSeen <= 1'b0;
      end else begin
         btnCleanDly <= btnClean;
         if (syncFill[1] && !btnSync && !btnClean) begin
            releaseSeen <= 1'b1;
         end
      end
   end

   assign cleanRise = btnClean & ~btnCleanDly & releaseSeen;

   // Handshake state register; goOut is its own flop so the downstream machine sees a glitch-free level.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         state <= S_IDLE;
         goOut <= 1'b0;
      end else begin
         state <= stateNext;
         goOut <= (stateNext == S_REQ);
      end
   end

   // Next-state logic: request on a clean rise, wait on done, re-arm only once done and button are both low.
   always_comb begin
      stateNext = state;
      case (state)
         S_IDLE: begin
            if (cleanRise) begin
               stateNext = S_REQ;
            end
         end
         S_REQ: begin
            if (doneSync) begin
               stateNext = S_RELEASE;
            end
         end
         S_RELEASE: begin
            if (!doneSync && !btnClean) begin
               stateNext = S_IDLE;
            end
         end
         default: begin
            stateNext = S_IDLE;
         end
      endcase
   end

   // Output decode: busy outside idle, and the single-cycle acceptance condition.
   always_comb begin
      busy      = (state != S_IDLE);
      idleToReq = (state == S_IDLE) && (stateNext == S_REQ);
   end

   // Accepted-request counter; wraps naturally at 8 bits.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         pressCount <= 8'd0;
      end else if (idleToReq) begin
         pressCount <= pressCount + 8'd1;
      end
   end

`ifdef GO_PULSE_OUT_EN
   // Strobe aligned with the first goOut cycle of each accepted request.
   always_ff @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         goPulse <= 1'b0;
      end else begin
         goPulse <= idleToReq;
      end
   end
`else
   assign goPulse = 1'b0;
`endif

endmodule

// File: tb/tb_go_request_conditioner.sv
// tb_go_request_conditioner: directed stimulus against a cycle-level behavioural model of the go request conditioner.
// Inputs change 2 time units after each rising edge; outputs are compared on every falling edge while out of reset.
// Hand-computed literal expectations at key cycles pin the model to the required timing.
`timescale 1ns/1ps
module tb_go_request_conditioner;

   localparam int DEB = 4;
`ifdef GO_PULSE_OUT_EN
   localparam bit PULSE_ON = 1'b1;
`else
   localparam bit PULSE_ON = 1'b0;
`endif
   localparam int P_IDLE = 0;
   localparam int P_REQ  = 1;
   localparam int P_REL  = 2;

   logic       clk = 1'b0;
   logic       rstN = 1'b0;
   logic       btnInput = 1'b0;
   logic       doneIn = 1'b0;
   logic       goOut;
   logic       busy;
   logic       btnClean;
   logic       goPulse;
   logic [7:0] pressCount;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   go_request_conditioner #(.DEBOUNCE_CYCLES(DEB)) dut (
      .clk(clk),
      .rstN(rstN),
      .btnInput(btnInput),
      .doneIn(doneIn),
      .goOut(goOut),
      .busy(busy),
      .btnClean(btnClean),
      .pressCount(pressCount),
      .goPulse(goPulse)
   );

   task automatic chk(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Behavioural model: delay line for synchronization, a run length of disagreeing samples for the
   // debounce, a flag recording a release seen since reset, and a three-phase handshake.
   logic d1, d2, e1, e2;
   logic mClean, mPrev, mArmed, mPulse;
   int   mRun, mFill, mPhase;
   logic [7:0] mCount;

   always @(posedge clk or negedge rstN) begin : model
      logic rise;
      if (!rstN) begin
         d1 = 0; d2 = 0; e1 = 0; e2 = 0;
         mClean = 0; mPrev = 0; mArmed = 0; mPulse = 0;
         mRun = 0; mFill = 0; mPhase = P_IDLE; mCount = 8'd0;
      end else begin
         rise = mClean && !mPrev && mArmed;
         mPulse = 0;
         case (mPhase)
            P_IDLE: if (rise) begin
               mPhase = P_REQ;
               mCount = mCount + 8'd1;
               mPulse = 1;
            end
            P_REQ: if (e2) mPhase = P_REL;
            default: if (!e2 && !mClean) mPhase = P_IDLE;
         endcase
         if (mFill >= 2 && !d2 && !mClean) mArmed = 1;
         if (mFill < 2) mFill++;
         mPrev = mClean;
         if (d2 != mClean) begin
            mRun++;
            if (mRun == DEB) begin
               mClean = !mClean;
               mRun = 0;
            end
         end else begin
            mRun = 0;
         end
         d2 = d1; d1 = btnInput;
         e2 = e1; e1 = doneIn;
      end
   end

   // Every-cycle comparison against the model.
   always @(negedge clk) begin
      if (rstN) begin
         chk("goOut", goOut, (mPhase == P_REQ));
         chk("busy", busy, (mPhase != P_IDLE));
         chk("btnClean", btnClean, mClean);
         chk("pressCount", pressCount, mCount);
         chk("goPulse", goPulse, PULSE_ON ? mPulse : 1'b0);
      end
   end

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   task automatic doPress();
      btnInput = 1; cyc(8);
      doneIn = 1;   cyc(4);
      btnInput = 0; doneIn = 0; cyc(8);
   endtask

   initial begin
      // Reset state
      cyc(3);
      chk("rst goOut", goOut, 0);
      chk("rst busy", busy, 0);
      chk("rst btnClean", btnClean, 0);
      chk("rst pressCount", pressCount, 0);
      chk("rst goPulse", goPulse, 0);
      rstN = 1;
      cyc(4);

      // Clean press: btnClean at cycle 6, goOut/busy at cycle 7
      btnInput = 1;
      cyc(5);
      chk("press c5 btnClean", btnClean, 0);
      cyc(1);
      chk("press c6 btnClean", btnClean, 1);
      chk("press c6 goOut", goOut, 0);
      cyc(1);
      chk("press c7 goOut", goOut, 1);
      chk("press c7 busy", busy, 1);
      chk("press c7 pressCount", pressCount, 1);
      chk("press c7 goPulse", goPulse, PULSE_ON);
      cyc(1);
      chk("press c8 goPulse", goPulse, 0);
      chk("press c8 goOut", goOut, 1);
      cyc(12);

      // Handshake: done -> goOut low 3 cycles later; held button keeps release
      doneIn = 1;
      cyc(2);
      chk("done c2 goOut", goOut, 1);
      cyc(1);
      chk("done c3 goOut", goOut, 0);
      chk("done c3 busy", busy, 1);
      doneIn = 0;
      cyc(10);
      chk("held busy", busy, 1);
      btnInput = 0;
      cyc(6);
      chk("release c6 busy", busy, 1);
      cyc(1);
      chk("release c7 busy", busy, 0);

      // Bounce: toggle every 2 cycles, settle low
      for (int i = 0; i < 8; i++) begin
         btnInput = ~btnInput;
         cyc(2);
      end
      btnInput = 0;
      cyc(10);
      chk("bounce btnClean", btnClean, 0);
      chk("bounce pressCount", pressCount, 1);
      chk("bounce goOut", goOut, 0);

      // Second press while in S_REQ is dropped
      btnInput = 1;
      cyc(7);
      chk("p2 goOut", goOut, 1);
      chk("p2 pressCount", pressCount, 2);
      btnInput = 0;
      cyc(8);
      chk("p2 released btnClean", btnClean, 0);
      chk("p2 still busy", busy, 1);
      btnInput = 1;
      cyc(8);
      chk("p3 btnClean", btnClean, 1);
      chk("p3 dropped pressCount", pressCount, 2);
      doneIn = 1;
      cyc(4);
      chk("p3 goOut after done", goOut, 0);
      doneIn = 0; btnInput = 0;
      cyc(8);
      chk("p3 idle", busy, 0);
      chk("p3 pressCount", pressCount, 2);

      // Wrap of pressCount
      for (int i = 0; i < 253; i++) doPress();
      chk("count 255", pressCount, 255);
      doPress();
      chk("count wrap", pressCount, 0);

      // Reset mid-S_REQ, then button held through reset release
      btnInput = 1;
      cyc(8);
      chk("pre-rst goOut", goOut, 1);
      chk("pre-rst pressCount", pressCount, 1);
      rstN = 0;
      #1;
      chk("async goOut", goOut, 0);
      chk("async busy", busy, 0);
      chk("async btnClean", btnClean, 0);
      chk("async pressCount", pressCount, 0);
      chk("async goPulse", goPulse, 0);
      cyc(2);
      rstN = 1;
      cyc(15);
      chk("held-thru-rst btnClean", btnClean, 1);
      chk("held-thru-rst goOut", goOut, 0);
      chk("held-thru-rst busy", busy, 0);
      chk("held-thru-rst pressCount", pressCount, 0);
      btnInput = 0;
      cyc(8);
      chk("after-rst release", btnClean, 0);
      btnInput = 1;
      cyc(7);
      chk("fresh press goOut", goOut, 1);
      chk("fresh press pressCount", pressCount, 1);
      cyc(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
